train_sequencer: RTL

// - Initiator for the fp/fp_out and bp/bp_out pulse handshake used by synapse and neuron.
// - Runs a batch of samples through a network:

---
 rtl/train_sequencer.sv | 209 ++++++++++++++++++++
 1 files changed

// File: rtl/train_sequencer.sv
// ----------------------------------------------------------------------------
// train_sequencer
// Initiator of the fp/fp_done and bp/bp_done pulse handshakes for a layered
// network. For each sample of a batch it issues a forward pulse and waits for
// the last layer to finish. In training mode it then issues a backward pulse,
// waits for the first layer to finish, and strobes a weight update. It steps
// sample_idx between samples so the input and target buffers can present the
// next a, t and w_in values.
//
// Optional feature (macro TRAIN_SEQ_TIMEOUT_EN):
//   defined   - FWAIT/BWAIT are bounded to WAIT_CYCLES cycles. When the bound
//               expires, the sticky timeout flag is set and the batch ends.
//   undefined - the wait states wait indefinitely and timeout stays 0.
//
// Ports
//   clk         in   system clock, rising edge
//   rst_n       in   asynchronous active-low reset
//   start       in   1-cycle pulse that begins a batch (ignored while busy)
//   train       in   sampled at start: 1 = fwd+bwd+update, 0 = forward only
//   batch_len   in   sampled at start: number of samples (0 = none)
//   abort       in   ends the running batch through DONE
//   fp          out  1-cycle forward-propagate pulse
//   fp_done     in   completion pulse from the last layer
//   bp          out  1-cycle backprop pulse
//   bp_done     in   completion pulse from the first layer
//   wu          out  1-cycle weight-update strobe
//   sample_idx  out  index of the sample in flight
//   busy        out  high while a batch is in progress (not in DONE)
//   done        out  1-cycle pulse at batch end or abort
//   timeout     out  sticky wait-timeout flag, cleared by the next start
// ----------------------------------------------------------------------------
module train_sequencer #(
  parameter int IDX_WIDTH   = 8,
  parameter int WAIT_CYCLES = 255
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 train,
  input  logic [IDX_WIDTH-1:0] batch_len,
  input  logic                 abort,
  output logic                 fp,
  input  logic                 fp_done,
  output logic                 bp,
  input  logic                 bp_done,
  output logic                 wu,
  output logic [IDX_WIDTH-1:0] sample_idx,
  output logic                 busy,
  output logic                 done,
  output logic                 timeout
);

  if (WAIT_CYCLES < 1) begin : g_bad_wait
    $error("WAIT_CYCLES must be at least 1");
  end

  localparam logic [IDX_WIDTH-1:0] IDX_ONE = {{(IDX_WIDTH-1){1'b0}}, 1'b1};

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FWD   = 3'd1,
    S_FWAIT = 3'd2,
    S_BWD   = 3'd3,
    S_BWAIT = 3'd4,
    S_UPD   = 3'd5,
    S_NEXT  = 3'd6,
    S_DONE  = 3'd7
  } state_e;

  state_e               state_q, state_d;
  logic                 train_q, train_d;
  logic [IDX_WIDTH-1:0] len_q, len_d;
  logic [IDX_WIDTH-1:0] idx_q, idx_d;
  logic                 timeout_q, timeout_d;
  logic                 fp_q, bp_q, wu_q, done_q, busy_q;
  logic                 wait_expired_s;

`ifdef TRAIN_SEQ_TIMEOUT_EN
  localparam int CW = $clog2(WAIT_CYCLES + 1);
  logic [CW-1:0] cnt_q, cnt_d;

  // Wait-cycle counter: counts while staying in a wait state, clears otherwise,
  // so each entry into FWAIT/BWAIT starts from zero.
  always_comb begin
    cnt_d = {CW{1'b0}};
    if (((state_q == S_FWAIT) || (state_q == S_BWAIT)) && (state_d == state_q)) begin
      cnt_d = cnt_q + {{(CW-1){1'b0}}, 1'b1};
    end else begin
      cnt_d = {CW{1'b0}};
    end
  end

  // Wait-cycle counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= {CW{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // The last permitted wait cycle is the one where the count reads WAIT_CYCLES-1.
  assign wait_expired_s = ((state_q == S_FWAIT) || (state_q == S_BWAIT)) &&
                          (cnt_q == CW'(WAIT_CYCLES - 1));
`else
  assign wait_expired_s = 1'b0;
`endif

  // Next-state logic and batch bookkeeping.
  always_comb begin
    state_d   = state_q;
    train_d   = train_q;
    len_d     = len_q;
    idx_d     = idx_q;
    timeout_d = timeout_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          train_d   = train;
          len_d     = batch_len;
          idx_d     = {IDX_WIDTH{1'b0}};
          timeout_d = 1'b0;
          state_d   = (batch_len != {IDX_WIDTH{1'b0}}) ? S_FWD : S_DONE;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_FWD:   state_d = S_FWAIT;
      S_FWAIT: begin
        if (fp_done) begin
          state_d = train_q ? S_BWD : S_NEXT;
        end else if (wait_expired_s) begin
          timeout_d = 1'b1;
          state_d   = S_DONE;
        end else begin
          state_d = S_FWAIT;
        end
      end
      S_BWD:   state_d = S_BWAIT;
      S_BWAIT: begin
        if (bp_done) begin
          state_d = S_UPD;
        end else if (wait_expired_s) begin
          timeout_d = 1'b1;
          state_d   = S_DONE;
        end else begin
          state_d = S_BWAIT;
        end
      end
      S_UPD:   state_d = S_NEXT;
      S_NEXT: begin
        if (idx_q == (len_q - IDX_ONE)) begin
          state_d = S_DONE;
        end else begin
          idx_d   = idx_q + IDX_ONE;
          state_d = S_FWD;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    // Abort overrides every in-batch transition. DONE is already on its way
    // out, so it is left alone to keep done a single pulse.
    if (abort && (state_q != S_IDLE) && (state_q != S_DONE)) begin
      state_d   = S_DONE;
      idx_d     = idx_q;
      timeout_d = timeout_q;
    end else begin
      state_d = state_d;
    end
  end

  // State, latches and registered output decode.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      train_q   <= 1'b0;
      len_q     <= {IDX_WIDTH{1'b0}};
      idx_q     <= {IDX_WIDTH{1'b0}};
      timeout_q <= 1'b0;
      fp_q      <= 1'b0;
      bp_q      <= 1'b0;
      wu_q      <= 1'b0;
      done_q    <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      train_q   <= train_d;
      len_q     <= len_d;
      idx_q     <= idx_d;
      timeout_q <= timeout_d;
      fp_q      <= (state_d == S_FWD);
      bp_q      <= (state_d == S_BWD);
      wu_q      <= (state_d == S_UPD);
      done_q    <= (state_d == S_DONE);
      busy_q    <= (state_d != S_IDLE) && (state_d != S_DONE);
    end
  end

  // An abort arriving during a pulse cycle suppresses that pulse.
  assign fp         = fp_q & ~abort;
  assign bp         = bp_q & ~abort;
  assign wu         = wu_q & ~abort;
  assign done       = done_q;
  assign busy       = busy_q;
  assign sample_idx = idx_q;
  assign timeout    = timeout_q;

endmodule
